pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised pipeline stage register for the pipelined core, generalising the fixed fetch/decode stage register into a reusable payload register with valid/ready flow control. It holds one payload plus an optional one-entry skid buffer, so upstream stall can be registered instead of combinational. It also supports flush to a programmable bubble value and keeps a saturating stall-cycle counter for performance monitoring. One instance sits between each pair of adjacent pipeline stages, with the hazard unit driving stall and flush.

## Interface

Parameters:
- WIDTH, 96, payload width in bits (e.g. instruction + PC + PC+4).
- FLUSH_VALUE, {WIDTH{1'b0}}, payload driven on o_Data after reset or flush.
- SKID_EN, 1, 1 = skid entry present and o_Ready registered; 0 = single entry with combinational o_Ready.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- i_Clk  input  1  clock, all state updates on rising edge.
- i_Reset  input  1  asynchronous, active-high reset.
- i_Valid  input  1  upstream payload valid.
- i_Data  input  WIDTH  upstream payload.
- o_Ready  output  1  stage can accept a payload this cycle.
- i_Stall  input  1  downstream (hazard unit) stall; output payload must be held.
- i_Flush  input  1  synchronous flush; discards all held and incoming payloads.
- o_Valid  output  1  o_Data holds a valid payload.
- o_Data  output  WIDTH  payload to downstream stage.
- o_Occupancy  output  2  number of held entries (0, 1, 2).
- o_StallCycles  output  CNT_W  saturating count of cycles with o_Valid & i_Stall.

## Operation

- Accept is defined as i_Valid & o_Ready. Release is defined as o_Valid & ~i_Stall.
- States: EMPTY (occupancy 0), MAIN (1, payload in main register), FULL (2, main + skid; SKID_EN=1 only).
- EMPTY: on accept, go to MAIN with main <= i_Data; otherwise stay.
- MAIN:
  - accept & release: stay in MAIN, main <= i_Data.
  - accept & ~release: go to FULL, skid <= i_Data (SKID_EN=1).
  - ~accept & release: go to EMPTY.
  - Otherwise hold.
- FULL: o_Ready=0, so no accept is possible. On release, go to MAIN with main <= skid. Otherwise hold.
- o_Ready:
  - SKID_EN=1: registered, equal to (next state != FULL).
  - SKID_EN=0: combinational, ~o_Valid | ~i_Stall.
- o_Valid = (state != EMPTY). o_Data = main register.
- In EMPTY, o_Data keeps its last value. The exception is after reset or flush, when it equals FLUSH_VALUE.
- Flush priority: reset > flush > all other events.
  - Flush forces EMPTY and sets main <= FLUSH_VALUE.
  - The skid entry and any same-cycle accept are discarded.
  - o_Ready=1 in the following cycle.
- Stall counter:
  - Increments each cycle in which o_Valid & i_Stall is true.
  - Saturates at 2^CNT_W-1 without wrapping.
  - Cleared by reset only; not cleared by flush.
  - The flush cycle still counts if o_Valid & i_Stall is true in that cycle.
- Payload ordering is strictly FIFO. No payload is duplicated or dropped except by flush.

## Timing

- Reset values (asynchronous, immediate): state EMPTY, o_Valid=0, o_Data=FLUSH_VALUE, o_Occupancy=0, o_StallCycles=0, skid=FLUSH_VALUE.
- o_Ready after reset: 1 in both modes (SKID_EN=1 registered reset value; SKID_EN=0 because ~o_Valid=1).
- Latency: a payload accepted on edge N appears on o_Data with o_Valid=1 after edge N, when arriving in EMPTY or in MAIN with release.
- Payload held in skid: appears on o_Data after the first edge with release.
- SKID_EN=1: o_Ready depends only on registered state and has no combinational path from i_Stall.
- Reset deasserted mid-stream: first accept is possible on the first rising edge after deassertion.
- Flush and stall asserted together: flush wins, and o_Valid=0 after the edge.

## Test plan

- Reset with SKID_EN=1, WIDTH=32, FLUSH_VALUE=32'h00000013 -> o_Valid=0, o_Data=32'h00000013, o_Ready=1, o_StallCycles=0.
- Stream 0xA0..0xA7, one payload per cycle, i_Stall=0 -> o_Data follows with 1-cycle latency, o_Occupancy stays 1, all 8 payloads in order.
- Send 0xB0 then 0xB1 on consecutive cycles while i_Stall=1 for 3 cycles -> occupancy reaches 2 and o_Ready=0. On stall release, 0xB0 then 0xB1 are output; o_StallCycles=3.
- In FULL (0xC0 main, 0xC1 skid), assert i_Flush with i_Valid=1, i_Data=0xC2 -> next cycle o_Valid=0, o_Data=0x13, o_Ready=1, and 0xC0, 0xC1, 0xC2 never appear.
- CNT_W=3, hold o_Valid=1 with i_Stall=1 for 10 cycles -> o_StallCycles reads 7 and does not wrap.
- SKID_EN=0, MAIN holding 0xD0, i_Stall=1 -> o_Ready=0 in the same cycle; after i_Stall drops with i_Valid=1, i_Data=0xD1, o_Data=0xD1 one edge later.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, optional one-entry skid buffer,
// flush to a bubble value and a saturating stall-cycle counter.
module pipe_stage_skid #(
  parameter int               WIDTH       = 96,
  parameter logic [WIDTH-1:0] FLUSH_VALUE = {WIDTH{1'b0}},
  parameter bit               SKID_EN     = 1'b1,
  parameter int               CNT_W       = 16
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic             i_Valid,
  input  logic [WIDTH-1:0] i_Data,
  output logic             o_Ready,
  input  logic             i_Stall,
  input  logic             i_Flush,
  output logic             o_Valid,
  output logic [WIDTH-1:0] o_Data,
  output logic [1:0]       o_Occupancy,
  output logic [CNT_W-1:0] o_StallCycles
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MAIN  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic [CNT_W-1:0] stall_cnt;
  logic             accept;
  logic             do_release;
  logic             load_main_in;
  logic             load_main_skid;
  logic             load_skid;

  assign accept     = i_Valid & o_Ready;
  assign do_release = o_Valid & ~i_Stall;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) state <= EMPTY;
    else         state <= state_next;
  end

  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (i_Flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_next   = MAIN;
            load_main_in = 1'b1;
          end
        end
        MAIN: begin
          if (accept && do_release) begin
            load_main_in = 1'b1;
          end else if (accept && SKID_EN) begin
            state_next = FULL;
            load_skid  = 1'b1;
          end else if (do_release) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (do_release) begin
            state_next     = MAIN;
            load_main_skid = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_comb begin
    o_Valid     = (state != EMPTY);
    o_Occupancy = 2'd0;
    case (state)
      MAIN:    o_Occupancy = 2'd1;
      FULL:    o_Occupancy = 2'd2;
      default: o_Occupancy = 2'd0;
    endcase
  end

  // The main register is left untouched on drain so an empty stage keeps showing its last payload.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      main_q <= FLUSH_VALUE;
      skid_q <= FLUSH_VALUE;
    end else if (i_Flush) begin
      main_q <= FLUSH_VALUE;
      skid_q <= FLUSH_VALUE;
    end else begin
      if (load_main_in)        main_q <= i_Data;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= i_Data;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      stall_cnt <= '0;
    end else if (o_Valid && i_Stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_Data        = main_q;
  assign o_StallCycles = stall_cnt;

  // With a skid entry, ready is registered so upstream never sees a path from i_Stall.
  generate
    if (SKID_EN) begin : g_skid
      logic ready_q;
      always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) ready_q <= 1'b1;
        else         ready_q <= (state_next != FULL);
      end
      assign o_Ready = ready_q;
    end else begin : g_noskid
      assign o_Ready = ~o_Valid | ~i_Stall;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: three instances (skid, skid with 3-bit counter, no skid)
// share one stimulus stream and are compared against a FIFO-level reference model.
module tb_pipe_stage_skid;

  localparam logic [31:0] FV = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_stall = 1'b0;
  logic        in_flush = 1'b0;

  logic        a_ready, a_valid, b_ready, b_valid, c_ready, c_valid;
  logic [31:0] a_data, b_data, c_data;
  logic [1:0]  a_occ, b_occ, c_occ;
  logic [15:0] a_cnt, c_cnt;
  logic [2:0]  b_cnt;

  logic        act_ready [3];
  logic        act_valid [3];
  logic [31:0] act_data  [3];
  logic [1:0]  act_occ   [3];
  logic [15:0] act_cnt   [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.WIDTH(32), .FLUSH_VALUE(FV), .SKID_EN(1'b1), .CNT_W(16)) dut_a (
    .i_Clk(clk), .i_Reset(rst), .i_Valid(in_valid), .i_Data(in_data), .o_Ready(a_ready),
    .i_Stall(in_stall), .i_Flush(in_flush), .o_Valid(a_valid), .o_Data(a_data),
    .o_Occupancy(a_occ), .o_StallCycles(a_cnt));

  pipe_stage_skid #(.WIDTH(32), .FLUSH_VALUE(FV), .SKID_EN(1'b1), .CNT_W(3)) dut_b (
    .i_Clk(clk), .i_Reset(rst), .i_Valid(in_valid), .i_Data(in_data), .o_Ready(b_ready),
    .i_Stall(in_stall), .i_Flush(in_flush), .o_Valid(b_valid), .o_Data(b_data),
    .o_Occupancy(b_occ), .o_StallCycles(b_cnt));

  pipe_stage_skid #(.WIDTH(32), .FLUSH_VALUE(FV), .SKID_EN(1'b0), .CNT_W(16)) dut_c (
    .i_Clk(clk), .i_Reset(rst), .i_Valid(in_valid), .i_Data(in_data), .o_Ready(c_ready),
    .i_Stall(in_stall), .i_Flush(in_flush), .o_Valid(c_valid), .o_Data(c_data),
    .o_Occupancy(c_occ), .o_StallCycles(c_cnt));

  assign act_ready[0] = a_ready;  assign act_valid[0] = a_valid;
  assign act_data[0]  = a_data;   assign act_occ[0]   = a_occ;   assign act_cnt[0] = a_cnt;
  assign act_ready[1] = b_ready;  assign act_valid[1] = b_valid;
  assign act_data[1]  = b_data;   assign act_occ[1]   = b_occ;   assign act_cnt[1] = {13'd0, b_cnt};
  assign act_ready[2] = c_ready;  assign act_valid[2] = c_valid;
  assign act_data[2]  = c_data;   assign act_occ[2]   = c_occ;   assign act_cnt[2] = c_cnt;

  // Reference model: each stage is a bounded FIFO of held payloads plus the last value shown.
  int          m_occ  [3];
  logic [31:0] m_held [3][2];
  logic [31:0] m_last [3];
  bit          m_ready[3];
  int          m_cnt  [3];

  function automatic int cntMax(input int k);
    return (k == 1) ? 7 : 65535;
  endfunction

  function automatic bit skidOn(input int k);
    return (k != 2);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 3; k++) begin
      m_occ[k]     = 0;
      m_held[k][0] = FV;
      m_held[k][1] = FV;
      m_last[k]    = FV;
      m_ready[k]   = 1'b1;
      m_cnt[k]     = 0;
    end
  endtask

  task automatic modelEdge();
    for (int k = 0; k < 3; k++) begin
      bit vld, rdy, acc, rel;
      vld = (m_occ[k] > 0);
      rdy = skidOn(k) ? m_ready[k] : (!vld || !in_stall);
      acc = in_valid && rdy;
      rel = vld && !in_stall;
      if (vld && in_stall && m_cnt[k] < cntMax(k)) m_cnt[k]++;
      if (in_flush) begin
        m_occ[k]  = 0;
        m_last[k] = FV;
      end else begin
        if (rel) begin
          m_last[k]    = m_held[k][0];
          m_held[k][0] = m_held[k][1];
          m_occ[k]--;
        end
        if (acc) begin
          m_held[k][m_occ[k]] = in_data;
          m_occ[k]++;
        end
      end
      m_ready[k] = (m_occ[k] < 2);
    end
  endtask

  task automatic checkModel();
    for (int k = 0; k < 3; k++) begin
      logic [31:0] exp_data;
      bit          exp_ready;
      exp_data  = (m_occ[k] > 0) ? m_held[k][0] : m_last[k];
      exp_ready = skidOn(k) ? m_ready[k] : (m_occ[k] == 0 || !in_stall);
      check($sformatf("dut%0d_valid", k), 64'(act_valid[k]), 64'(m_occ[k] > 0));
      check($sformatf("dut%0d_data", k),  64'(act_data[k]),  64'(exp_data));
      check($sformatf("dut%0d_occ", k),   64'(act_occ[k]),   64'(m_occ[k]));
      check($sformatf("dut%0d_ready", k), 64'(act_ready[k]), 64'(exp_ready));
      check($sformatf("dut%0d_cnt", k),   64'(act_cnt[k]),   64'(m_cnt[k]));
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare every instance with the model.
  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic st, input logic fl);
    in_valid = v;
    in_data  = d;
    in_stall = st;
    in_flush = fl;
    modelEdge();
    @(posedge clk);
    #1;
    checkModel();
  endtask

  task automatic doReset();
    in_valid = 1'b0;
    in_data  = '0;
    in_stall = 1'b0;
    in_flush = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    modelReset();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst%0d_valid", k), 64'(act_valid[k]), 64'd0);
      check($sformatf("rst%0d_data", k),  64'(act_data[k]),  64'(FV));
      check($sformatf("rst%0d_occ", k),   64'(act_occ[k]),   64'd0);
      check($sformatf("rst%0d_ready", k), 64'(act_ready[k]), 64'd1);
      check($sformatf("rst%0d_cnt", k),   64'(act_cnt[k]),   64'd0);
    end
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        st;
    logic        fl;
    logic        ev;
    logic [31:0] ed;
    logic [1:0]  eo;
    logic        er;
    int          ec;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkVec(input logic v, input logic [31:0] d, input logic st, input logic fl,
                                 input logic ev, input logic [31:0] ed, input logic [1:0] eo,
                                 input logic er, input int ec);
    vec_t r;
    r.v = v; r.d = d; r.st = st; r.fl = fl;
    r.ev = ev; r.ed = ed; r.eo = eo; r.er = er; r.ec = ec;
    return r;
  endfunction

  task automatic checkOutput(input int idx, input vec_t t);
    check($sformatf("vec%0d_valid", idx), 64'(a_valid), 64'(t.ev));
    check($sformatf("vec%0d_data", idx),  64'(a_data),  64'(t.ed));
    check($sformatf("vec%0d_occ", idx),   64'(a_occ),   64'(t.eo));
    check($sformatf("vec%0d_ready", idx), 64'(a_ready), 64'(t.er));
    check($sformatf("vec%0d_cnt", idx),   64'(a_cnt),   64'(t.ec));
  endtask

  initial begin
    // Streaming, skid fill/drain and flush-in-FULL sequences for the skid instance.
    for (int i = 0; i < 8; i++)
      vecs.push_back(mkVec(1, 32'hA0 + 32'(i), 0, 0, 1, 32'hA0 + 32'(i), 2'd1, 1, 0));
    vecs.push_back(mkVec(0, 32'h0,  0, 0, 0, 32'hA7, 2'd0, 1, 0));
    vecs.push_back(mkVec(1, 32'hB0, 0, 0, 1, 32'hB0, 2'd1, 1, 0));
    vecs.push_back(mkVec(1, 32'hB1, 1, 0, 1, 32'hB0, 2'd2, 0, 1));
    vecs.push_back(mkVec(0, 32'h0,  1, 0, 1, 32'hB0, 2'd2, 0, 2));
    vecs.push_back(mkVec(0, 32'h0,  1, 0, 1, 32'hB0, 2'd2, 0, 3));
    vecs.push_back(mkVec(0, 32'h0,  0, 0, 1, 32'hB1, 2'd1, 1, 3));
    vecs.push_back(mkVec(0, 32'h0,  0, 0, 0, 32'hB1, 2'd0, 1, 3));
    vecs.push_back(mkVec(1, 32'hC0, 0, 0, 1, 32'hC0, 2'd1, 1, 3));
    vecs.push_back(mkVec(1, 32'hC1, 1, 0, 1, 32'hC0, 2'd2, 0, 4));
    vecs.push_back(mkVec(1, 32'hC2, 1, 1, 0, FV,     2'd0, 1, 5));
    vecs.push_back(mkVec(0, 32'h0,  0, 0, 0, FV,     2'd0, 1, 5));
    vecs.push_back(mkVec(0, 32'h0,  1, 0, 0, FV,     2'd0, 1, 5));

    doReset();
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].v, vecs[i].d, vecs[i].st, vecs[i].fl);
      checkOutput(i, vecs[i]);
    end

    // Counter saturation: 3-bit counter must stop at 7 while the 16-bit one reaches 10.
    doReset();
    applyStimulus(1, 32'hE0, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 32'h0, 1, 0);
    check("sat_b_cnt", 64'(b_cnt), 64'd7);
    check("sat_a_cnt", 64'(a_cnt), 64'd10);
    check("sat_b_valid", 64'(b_valid), 64'd1);
    applyStimulus(0, 32'h0, 0, 0);
    check("sat_b_hold", 64'(b_cnt), 64'd7);

    // Single-entry mode: ready drops combinationally with stall, then pass-through on release.
    doReset();
    applyStimulus(1, 32'hD0, 0, 0);
    in_stall = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hD1;
    #1;
    check("noskid_ready_comb", 64'(c_ready), 64'd0);
    check("skid_ready_reg", 64'(a_ready), 64'd1);
    check("noskid_data_held", 64'(c_data), 64'hD0);
    applyStimulus(1, 32'hD1, 0, 0);
    check("noskid_data_next", 64'(c_data), 64'hD1);
    check("noskid_valid_next", 64'(c_valid), 64'd1);

    // Randomised traffic against the model for all three instances.
    doReset();
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 9) < 4),
                    1'($urandom_range(0, 19) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
